// File: rtl/pp_csa_accum_ctrl.sv
// Controller that drives an external 4:2 compressor to fold Booth radix-4 partial
// products (two per beat) into a carry-save accumulator, one frame at a time.
module pp_csa_accum_ctrl #(
  parameter int WIDTH  = 256,
  parameter int NUM_PP = 8,
  parameter int CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic             i_pp_valid,
  output logic             o_pp_ready,
  input  logic [WIDTH-1:0] i_pp_a,
  input  logic [WIDTH-1:0] i_pp_b,
  input  logic             i_pp_cin,
  input  logic             i_pp_last,
  output logic [WIDTH-1:0] o_cmp_in1,
  output logic [WIDTH-1:0] o_cmp_in2,
  output logic [WIDTH-1:0] o_cmp_in3,
  output logic [WIDTH-1:0] o_cmp_in4,
  output logic             o_cmp_cin,
  input  logic [WIDTH:0]   i_cmp_out1,
  input  logic [WIDTH:0]   i_cmp_out2,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_sum,
  output logic [WIDTH-1:0] o_res_carry,
  output logic             o_err_len,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] BEATS = CNT_W'(NUM_PP / 2);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_accS;
  logic [WIDTH-1:0] r_accC;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_resSum;
  logic [WIDTH-1:0] r_resCarry;
  logic             r_resValid;
  logic             r_errLen;

  logic             w_beat;
  logic             w_lastCnt;
  logic             w_frameEnd;
  logic [WIDTH-1:0] w_newS;
  logic [WIDTH-1:0] w_newC;
  logic             w_unused;

  assign o_cmp_in1 = r_accS;
  assign o_cmp_in2 = r_accC;
  assign o_cmp_in3 = i_pp_a;
  assign o_cmp_in4 = i_pp_b;
  assign o_cmp_cin = i_pp_cin;

  // Dropping the compressor's top bit is the mod 2^WIDTH wrap of the accumulator.
  assign w_newS    = i_cmp_out1[WIDTH-1:0];
  assign w_newC    = i_cmp_out2[WIDTH-1:0];
  assign w_unused  = i_cmp_out1[WIDTH] ^ i_cmp_out2[WIDTH];

  assign w_beat     = (r_state == S_ACCUM) && i_pp_valid;
  assign w_lastCnt  = (r_cnt == ONE);
  assign w_frameEnd = w_lastCnt || i_pp_last;

  assign o_start_ready = (r_state == S_IDLE);
  assign o_pp_ready    = (r_state == S_ACCUM);
  assign o_busy        = (r_state != S_IDLE);
  assign o_res_valid   = r_resValid;
  assign o_res_sum     = r_resSum;
  assign o_res_carry   = r_resCarry;
  assign o_err_len     = r_errLen;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_accS     <= '0;
      r_accC     <= '0;
      r_cnt      <= '0;
      r_resSum   <= '0;
      r_resCarry <= '0;
      r_resValid <= 1'b0;
      r_errLen   <= 1'b0;
    end else begin
      r_errLen <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_valid) begin
            r_accS  <= '0;
            r_accC  <= '0;
            r_cnt   <= BEATS;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_beat) begin
            r_accS   <= w_newS;
            r_accC   <= w_newC;
            r_cnt    <= r_cnt - ONE;
            r_errLen <= w_lastCnt != i_pp_last;
            if (w_frameEnd) begin
              r_resSum   <= w_newS;
              r_resCarry <= w_newC;
              r_resValid <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // A start request here is ignored; only the result handshake leaves DONE.
          if (i_res_ready) begin
            r_resValid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_resValid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
